// File: rtl/phase_sequencer_pkg.sv
// Shared constants and types for the CPU run/stop phase sequencer.
// Phase 0 is idle; phases 1..PH_LAST make up one instruction.
package phase_sequencer_pkg;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_LAST = 3'd5;
    localparam int         PC_W    = 16;

    typedef enum logic [0:0] {
        SEQ_IDLE   = 1'b0,
        SEQ_ACTIVE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/debug bundle between the phase sequencer (slave) and the core/board (master).
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    import phase_sequencer_pkg::*;

    logic             exec;
    logic             step_mode;
    logic             hlt;
    logic             stall;
    logic [PC_W-1:0]  pc;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [2:0]       phase;
    logic             executing;
    logic             halted;
    logic             bp_hit;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output exec, step_mode, hlt, stall, pc, bp_en, bp_addr,
        input  phase, executing, halted, bp_hit, instr_done, instr_count
    );

    modport slave (
        input  exec, step_mode, hlt, stall, pc, bp_en, bp_addr,
        output phase, executing, halted, bp_hit, instr_done, instr_count
    );

endinterface

// File: rtl/phase_sequencer_btn_debounce.sv
// EXEC button conditioning: 2-FF synchroniser, debounce and press (falling-edge) pulse.
// A level change is accepted only after DEB_CYCLES consecutive samples disagree with it.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int             CW      = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;

    // Synchronise, debounce and emit a single pulse when the accepted level falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            stable_r <= 1'b1;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
                press_r  <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/phase_sequencer.sv
// Run/stop controller and instruction phase sequencer for the 16-bit multi-cycle core,
// with single-step, breakpoint and retired-instruction counter for board debug.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NPHASE     = int'(PH_LAST),
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    phase_sequencer_if.slave   bus
);

    localparam logic [2:0] LAST = 3'(NPHASE);

    seq_state_t       state_r;
    logic [2:0]       phase_r;
    logic             stop_req_r;
    logic             halt_seen_r;
    logic             halted_r;
    logic             bp_hit_r;
    logic             instr_done_r;
    logic [CNT_W-1:0] instr_count_r;

    logic press_s;
    logic stop_now_s;
    logic halt_now_s;
    logic bp_match_s;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.exec),
        .press (press_s)
    );

    // Stop/halt requests including this cycle's events, so a press or HLT in the
    // last phase still applies to the instruction that is retiring.
    always_comb begin
        stop_now_s = stop_req_r | press_s | bus.hlt;
        halt_now_s = halt_seen_r | bus.hlt;
        bp_match_s = bus.bp_en & (bus.pc == bus.bp_addr);
    end

    // Sequencer FSM: phase count, sticky stop causes and retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= SEQ_IDLE;
            phase_r       <= PH_IDLE;
            stop_req_r    <= 1'b0;
            halt_seen_r   <= 1'b0;
            halted_r      <= 1'b0;
            bp_hit_r      <= 1'b0;
            instr_done_r  <= 1'b0;
            instr_count_r <= '0;
        end else begin
            instr_done_r <= 1'b0;
            case (state_r)
                SEQ_IDLE: begin
                    if (press_s) begin
                        state_r     <= SEQ_ACTIVE;
                        phase_r     <= 3'd1;
                        halted_r    <= 1'b0;
                        bp_hit_r    <= 1'b0;
                        stop_req_r  <= bus.step_mode;
                        halt_seen_r <= 1'b0;
                    end else begin
                        phase_r <= PH_IDLE;
                    end
                end
                SEQ_ACTIVE: begin
                    if (bus.stall) begin
                        stop_req_r  <= stop_now_s;
                        halt_seen_r <= halt_now_s;
                    end else if (phase_r != LAST) begin
                        phase_r     <= phase_r + 3'd1;
                        stop_req_r  <= stop_now_s;
                        halt_seen_r <= halt_now_s;
                    end else begin
                        // Instruction boundary: retire, then decide whether to continue.
                        instr_done_r  <= 1'b1;
                        instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        stop_req_r    <= 1'b0;
                        halt_seen_r   <= 1'b0;
                        if (halt_now_s) begin
                            state_r  <= SEQ_IDLE;
                            phase_r  <= PH_IDLE;
                            halted_r <= 1'b1;
                        end else if (bp_match_s) begin
                            state_r  <= SEQ_IDLE;
                            phase_r  <= PH_IDLE;
                            bp_hit_r <= 1'b1;
                        end else if (stop_now_s) begin
                            state_r <= SEQ_IDLE;
                            phase_r <= PH_IDLE;
                        end else begin
                            phase_r <= 3'd1;
                        end
                    end
                end
                default: begin
                    state_r <= SEQ_IDLE;
                    phase_r <= PH_IDLE;
                end
            endcase
        end
    end

    assign bus.phase       = phase_r;
    assign bus.executing   = (phase_r != PH_IDLE);
    assign bus.halted      = halted_r;
    assign bus.bp_hit      = bp_hit_r;
    assign bus.instr_done  = instr_done_r;
    assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (DEB_CYCLES = 4).
module tb_phase_sequencer;
    import phase_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_sequencer_if #(.CNT_W(16)) bus();

    phase_sequencer #(.NPHASE(5), .DEB_CYCLES(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit press_busy = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold EXEC low 10 cycles, then released long enough to debounce back high.
    task automatic press_seq;
        bus.exec = 1'b0;
        repeat (10) tick();
        bus.exec = 1'b1;
        repeat (10) tick();
        press_busy = 1'b0;
    endtask

    task automatic start_press;
        press_busy = 1'b1;
        fork
            press_seq();
        join_none
    endtask

    task automatic wait_release(output bit ok);
        for (int i = 0; i < 60 && press_busy; i++) tick();
        ok = !press_busy;
    endtask

    task automatic wait_phase(input logic [2:0] p, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (bus.phase === p) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset;
        rst = 1'b0;
        bus.exec = 1'b1; bus.step_mode = 1'b0; bus.hlt = 1'b0; bus.stall = 1'b0;
        bus.pc = 16'h0000; bus.bp_en = 1'b0; bus.bp_addr = 16'h0000;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        bus.exec = 1'b1; bus.step_mode = 1'b0; bus.hlt = 1'b0; bus.stall = 1'b0;
        bus.pc = 16'h0000; bus.bp_en = 1'b0; bus.bp_addr = 16'h0000;
        #2 rst = 1'b0;
        tick();
        n_checks++; if (bus.phase !== 3'd0) $display("FAIL reset_phase: got %0d expected 0", bus.phase); else n_pass++;
        n_checks++; if (bus.executing !== 1'b0) $display("FAIL reset_executing: got %0d expected 0", bus.executing); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %0d expected 0", bus.halted); else n_pass++;
        n_checks++; if (bus.bp_hit !== 1'b0) $display("FAIL reset_bp_hit: got %0d expected 0", bus.bp_hit); else n_pass++;
        n_checks++; if (bus.instr_done !== 1'b0) $display("FAIL reset_instr_done: got %0d expected 0", bus.instr_done); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", bus.instr_count); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_run;
        bit ok;
        logic [2:0] eph;
        logic [2:0] prev;
        int ecnt;
        bit pressed2;
        do_reset();
        start_press();
        wait_phase(3'd1, 30, ok);
        n_checks++; if (!ok) $display("FAIL run_start: got timeout expected phase 1"); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            eph = 3'((k % 5) + 1);
            n_checks++; if (bus.phase !== eph) $display("FAIL run_phase k=%0d: got %0d expected %0d", k, bus.phase, eph); else n_pass++;
            n_checks++; if (bus.instr_done !== (k > 0 && k % 5 == 0)) $display("FAIL run_done k=%0d: got %0d expected %0d", k, bus.instr_done, (k > 0 && k % 5 == 0)); else n_pass++;
            n_checks++; if (bus.instr_count !== 16'(k / 5)) $display("FAIL run_count k=%0d: got %0d expected %0d", k, bus.instr_count, k / 5); else n_pass++;
            tick();
        end
        // Stop with a second press; the instruction in flight must complete.
        prev = 3'd2; ecnt = 2; pressed2 = 1'b0; ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (prev == 3'd5) begin
                ecnt++;
                n_checks++; if (bus.phase !== 3'd1 && bus.phase !== 3'd0) $display("FAIL stop_boundary: got %0d expected 1 or 0", bus.phase); else n_pass++;
            end else begin
                n_checks++; if (bus.phase !== prev + 3'd1) $display("FAIL stop_seq: got %0d expected %0d", bus.phase, prev + 3'd1); else n_pass++;
            end
            n_checks++; if (bus.instr_done !== (prev == 3'd5)) $display("FAIL stop_done: got %0d expected %0d", bus.instr_done, (prev == 3'd5)); else n_pass++;
            n_checks++; if (bus.instr_count !== 16'(ecnt)) $display("FAIL stop_count: got %0d expected %0d", bus.instr_count, ecnt); else n_pass++;
            if (bus.phase === 3'd0) begin
                ok = 1'b1;
                break;
            end
            if (!press_busy && !pressed2) begin
                start_press();
                pressed2 = 1'b1;
            end
            prev = bus.phase;
            tick();
        end
        n_checks++; if (!ok) $display("FAIL run_stop: got timeout expected phase 0"); else n_pass++;
        wait_release(ok);
    endtask

    task automatic test_step;
        bit ok;
        do_reset();
        bus.step_mode = 1'b1;
        start_press();
        wait_phase(3'd1, 30, ok);
        n_checks++; if (!ok) $display("FAIL step_start: got timeout expected phase 1"); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus.phase !== 3'(k + 1)) $display("FAIL step_phase: got %0d expected %0d", bus.phase, k + 1); else n_pass++;
            tick();
        end
        n_checks++; if (bus.phase !== 3'd0) $display("FAIL step_end: got %0d expected 0", bus.phase); else n_pass++;
        n_checks++; if (bus.instr_done !== 1'b1) $display("FAIL step_done: got %0d expected 1", bus.instr_done); else n_pass++;
        n_checks++; if (bus.executing !== 1'b0) $display("FAIL step_exec: got %0d expected 0", bus.executing); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd1) $display("FAIL step_count1: got %0d expected 1", bus.instr_count); else n_pass++;
        wait_release(ok);
        n_checks++; if (bus.phase !== 3'd0) $display("FAIL step_hold: got %0d expected 0", bus.phase); else n_pass++;
        start_press();
        wait_phase(3'd1, 30, ok);
        wait_phase(3'd0, 20, ok);
        n_checks++; if (!ok) $display("FAIL step_second: got timeout expected phase 0"); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd2) $display("FAIL step_count2: got %0d expected 2", bus.instr_count); else n_pass++;
        wait_release(ok);
    endtask

    task automatic test_stall;
        bit ok;
        int cyc;
        int stalls;
        int n3;
        do_reset();
        bus.step_mode = 1'b1;
        start_press();
        wait_phase(3'd1, 30, ok);
        cyc = 0; stalls = 0; n3 = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.phase === 3'd0) break;
            if (bus.phase === 3'd3) n3++;
            if (bus.phase === 3'd3 && stalls < 3) begin
                bus.stall = 1'b1;
                stalls++;
            end else begin
                bus.stall = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.stall = 1'b0;
        n_checks++; if (cyc !== 8) $display("FAIL stall_len: got %0d expected 8", cyc); else n_pass++;
        n_checks++; if (n3 !== 4) $display("FAIL stall_hold: got %0d expected 4", n3); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd1) $display("FAIL stall_count: got %0d expected 1", bus.instr_count); else n_pass++;
        wait_release(ok);
    endtask

    task automatic test_hlt;
        bit ok;
        do_reset();
        bus.bp_en = 1'b1; bus.bp_addr = 16'h0010; bus.pc = 16'h0010;
        start_press();
        wait_phase(3'd2, 30, ok);
        bus.hlt = 1'b1;
        tick();
        bus.hlt = 1'b0;
        n_checks++; if (bus.phase !== 3'd3) $display("FAIL hlt_continue: got %0d expected 3", bus.phase); else n_pass++;
        wait_phase(3'd0, 20, ok);
        n_checks++; if (!ok) $display("FAIL hlt_stop: got timeout expected phase 0"); else n_pass++;
        n_checks++; if (bus.halted !== 1'b1) $display("FAIL hlt_halted: got %0d expected 1", bus.halted); else n_pass++;
        n_checks++; if (bus.bp_hit !== 1'b0) $display("FAIL hlt_over_bp: got %0d expected 0", bus.bp_hit); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd1) $display("FAIL hlt_count: got %0d expected 1", bus.instr_count); else n_pass++;
        wait_release(ok);
        start_press();
        wait_phase(3'd1, 30, ok);
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL hlt_clear: got %0d expected 0", bus.halted); else n_pass++;
        wait_phase(3'd0, 20, ok);
        n_checks++; if (bus.bp_hit !== 1'b1) $display("FAIL hlt_then_bp: got %0d expected 1", bus.bp_hit); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd2) $display("FAIL hlt_count2: got %0d expected 2", bus.instr_count); else n_pass++;
        wait_release(ok);
    endtask

    task automatic test_bp;
        bit ok;
        int n;
        do_reset();
        bus.bp_en = 1'b1; bus.bp_addr = 16'h0004; bus.pc = 16'h0001;
        n = 0;
        start_press();
        wait_phase(3'd1, 30, ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.instr_done === 1'b1) n++;
            bus.pc = 16'(n + 1);
            if (bus.phase === 3'd0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!ok) $display("FAIL bp_stop: got timeout expected phase 0"); else n_pass++;
        n_checks++; if (bus.bp_hit !== 1'b1) $display("FAIL bp_hit: got %0d expected 1", bus.bp_hit); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL bp_halted: got %0d expected 0", bus.halted); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd4) $display("FAIL bp_count: got %0d expected 4", bus.instr_count); else n_pass++;
        wait_release(ok);
        bus.pc = 16'h0004;
        start_press();
        wait_phase(3'd1, 30, ok);
        n_checks++; if (bus.bp_hit !== 1'b0) $display("FAIL bp_clear: got %0d expected 0", bus.bp_hit); else n_pass++;
        wait_phase(3'd0, 20, ok);
        n_checks++; if (bus.instr_count !== 16'd5) $display("FAIL bp_restart_count: got %0d expected 5", bus.instr_count); else n_pass++;
        n_checks++; if (bus.bp_hit !== 1'b1) $display("FAIL bp_restart_hit: got %0d expected 1", bus.bp_hit); else n_pass++;
        wait_release(ok);
    endtask

    task automatic test_bounce_reset;
        bit ok;
        bit started;
        do_reset();
        started = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.exec = ~bus.exec;
            tick();
            if (bus.phase !== 3'd0) started = 1'b1;
        end
        bus.exec = 1'b1;
        repeat (8) tick();
        n_checks++; if (started || bus.phase !== 3'd0) $display("FAIL bounce_start: got started=%0d phase=%0d expected 0", started, bus.phase); else n_pass++;
        start_press();
        wait_phase(3'd5, 30, ok);
        tick();
        wait_phase(3'd3, 10, ok);
        n_checks++; if (!ok || bus.instr_count !== 16'd1) $display("FAIL mid_setup: got count=%0d expected 1", bus.instr_count); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.phase !== 3'd0) $display("FAIL mid_phase: got %0d expected 0", bus.phase); else n_pass++;
        n_checks++; if (bus.executing !== 1'b0) $display("FAIL mid_exec: got %0d expected 0", bus.executing); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd0) $display("FAIL mid_count: got %0d expected 0", bus.instr_count); else n_pass++;
        n_checks++; if (bus.instr_done !== 1'b0) $display("FAIL mid_done: got %0d expected 0", bus.instr_done); else n_pass++;
        wait_release(ok);
        rst = 1'b1;
        repeat (10) tick();
        n_checks++; if (bus.phase !== 3'd0) $display("FAIL mid_after: got %0d expected 0", bus.phase); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_stall();
        test_hlt();
        test_bp();
        test_bounce_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
